rst_seq: RTL and testbench

//  Reset sequencer directly downstream of the two-flop reset synchronizer. Input rst is the synchronized board reset.

---
 rtl/rst_seq.sv | 142 ++++++++++++++
 tb/tb_rst_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// ============================================================================
//  Module   : rst_seq
//  Brief    : Ordered reset release for the peripheral and controller domains,
//             with init-timeout retry and lockout. Optional SOFT_RST_EN adds a
//             software re-sequence request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq #(
  parameter int STRETCH_CYC = 16,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int GAP_CYC     = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
`ifdef SOFT_RST_EN
  input  logic soft_rst_req,
`endif
  output logic rst_periph_n,
  output logic rst_ctrl_n,
  output logic seq_done,
  output logic timeout_err,
  output logic lockout
);

  localparam int c_MAX_SG  = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int c_CNT_MAX = (c_MAX_SG > TIMEOUT_CYC) ? c_MAX_SG : TIMEOUT_CYC;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_RTY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(STRETCH_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_RTY_W-1:0] c_RTY_SAT   = c_RTY_W'(MAX_RETRY + 1);
  localparam logic [c_RTY_W-1:0] c_RTY_LIM   = c_RTY_W'(MAX_RETRY);
  localparam logic [c_RTY_W-1:0] c_RTY_ONE   = c_RTY_W'(1);

  localparam logic [2:0] c_ST_HOLD   = 3'd0;
  localparam logic [2:0] c_ST_PERIPH = 3'd1;
  localparam logic [2:0] c_ST_GAP    = 3'd2;
  localparam logic [2:0] c_ST_RUN    = 3'd3;
  localparam logic [2:0] c_ST_FAULT  = 3'd4;

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_RTY_W-1:0] r_retry_cnt;
  logic               r_timeout_err;
  logic               r_lockout;
  logic [c_RTY_W-1:0] w_retry_inc;
  logic               w_soft_req;

  assign w_retry_inc = (r_retry_cnt == c_RTY_SAT) ? r_retry_cnt : r_retry_cnt + c_RTY_ONE;

`ifdef SOFT_RST_EN
  assign w_soft_req = soft_rst_req && (r_state != c_ST_HOLD);
`else
  assign w_soft_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_ST_HOLD;
      r_cnt         <= '0;
      r_retry_cnt   <= '0;
      r_timeout_err <= 1'b0;
      r_lockout     <= 1'b0;
    end else if (w_soft_req) begin
      r_state     <= c_ST_HOLD;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_lockout   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_state <= c_ST_PERIPH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_PERIPH: begin
          // init_done wins over a coincident timeout
          if (init_done) begin
            r_state <= c_ST_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == c_TMO_LAST) begin
            r_state       <= c_ST_FAULT;
            r_cnt         <= '0;
            r_timeout_err <= 1'b1;
            r_retry_cnt   <= w_retry_inc;
            if (w_retry_inc > c_RTY_LIM) r_lockout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_RUN: begin
          if (!init_done) begin
            r_state <= c_ST_HOLD;
            r_cnt   <= '0;
          end
        end
        c_ST_FAULT: begin
          // Once locked out the sequencer parks here until rst (or soft request)
          if (!r_lockout) begin
            if (r_cnt == c_HOLD_LAST) begin
              r_state <= c_ST_PERIPH;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
        end
        default: begin
          r_state <= c_ST_HOLD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rst_periph_n = (r_state == c_ST_PERIPH) || (r_state == c_ST_GAP) || (r_state == c_ST_RUN);
  assign rst_ctrl_n   = (r_state == c_ST_RUN);
  assign seq_done     = (r_state == c_ST_RUN);
  assign timeout_err  = r_timeout_err;
  assign lockout      = r_lockout;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
//  Module   : tb_rst_seq
//  Brief    : Self-checking bench for rst_seq (edge-count checkpoints).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
`ifdef SOFT_RST_EN
  logic soft_rst_req = 1'b0;
`endif
  logic rst_periph_n, rst_ctrl_n, seq_done, timeout_err, lockout;

  rst_seq #(
    .STRETCH_CYC(16),
    .TIMEOUT_CYC(100),
    .GAP_CYC    (4),
    .MAX_RETRY  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
`ifdef SOFT_RST_EN
    .soft_rst_req(soft_rst_req),
`endif
    .rst_periph_n(rst_periph_n),
    .rst_ctrl_n  (rst_ctrl_n),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .lockout     (lockout)
  );

  always #5 clk = ~clk;

  // Expected vector bits: {rst_periph_n, rst_ctrl_n, seq_done, timeout_err, lockout}
  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  typedef struct {
    bit         restart;
    logic       init_done;
    int         edge_n;
    logic [4:0] exp;
    string      name;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[0:15];
  int   n_vec;
  int   checks   = 0;
  int   failures = 0;
  int   cur_edge = 0;

  task automatic tick();
    sb_t e;
    logic [4:0] act;
    @(posedge clk);
    #1;
    act = {rst_periph_n, rst_ctrl_n, seq_done, timeout_err, lockout};
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b (edge %0d)", e.name, act, e.exp, cur_edge);
      end
    end
  endtask

  task automatic expect_next(input logic [4:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expect_next(5'b00000, "reset_state");
    tick();
    rst = 1'b0;
    cur_edge = 0;
  endtask

  // Advance to edge n (counting rst=0 edges) and check the outputs after it
  task automatic check_at(input int n, input logic [4:0] exp, input string name);
    while (cur_edge < n - 1) begin
      tick();
      cur_edge++;
    end
    expect_next(exp, name);
    tick();
    cur_edge++;
  endtask

  initial begin
    n_vec = 0;
    vt[n_vec++] = '{1'b1, 1'b1,  15, 5'b00000, "t1_hold_e15"};
    vt[n_vec++] = '{1'b0, 1'b1,  16, 5'b10000, "t1_periph_e16"};
    vt[n_vec++] = '{1'b0, 1'b1,  20, 5'b10000, "t1_gap_e20"};
    vt[n_vec++] = '{1'b0, 1'b1,  21, 5'b11100, "t1_run_e21"};
    vt[n_vec++] = '{1'b0, 1'b1,  30, 5'b11100, "t1_run_e30"};
    vt[n_vec++] = '{1'b1, 1'b0, 115, 5'b10000, "t2_periph_e115"};
    vt[n_vec++] = '{1'b0, 1'b0, 116, 5'b00010, "t2_fault1_e116"};
    vt[n_vec++] = '{1'b0, 1'b0, 131, 5'b00010, "t2_fault1_e131"};
    vt[n_vec++] = '{1'b0, 1'b0, 132, 5'b10010, "t2_retry1_e132"};
    vt[n_vec++] = '{1'b0, 1'b0, 232, 5'b00010, "t2_fault2_e232"};
    vt[n_vec++] = '{1'b0, 1'b0, 247, 5'b00010, "t2_fault2_e247"};
    vt[n_vec++] = '{1'b0, 1'b0, 248, 5'b10010, "t2_retry2_e248"};
    vt[n_vec++] = '{1'b0, 1'b0, 347, 5'b10010, "t2_periph_e347"};
    vt[n_vec++] = '{1'b0, 1'b0, 348, 5'b00011, "t2_lockout_e348"};
    vt[n_vec++] = '{1'b0, 1'b0, 420, 5'b00011, "t2_lockout_held"};

    for (int i = 0; i < n_vec; i++) begin
      init_done = vt[i].init_done;
      if (vt[i].restart) do_reset();
      check_at(vt[i].edge_n, vt[i].exp, vt[i].name);
    end

    // init_done arrives on the very edge the timeout would fire
    init_done = 1'b0;
    do_reset();
    check_at(115, 5'b10000, "t3_periph_e115");
    init_done = 1'b1;
    check_at(116, 5'b10000, "t3_gap_no_err");
    check_at(119, 5'b10000, "t3_gap_e119");
    check_at(120, 5'b11100, "t3_run_e120");

    // Brief init_done drop in RUN forces a full re-sequence
    init_done = 1'b0;
    check_at(121, 5'b00000, "t4_drop_hold");
    init_done = 1'b1;
    check_at(136, 5'b00000, "t4_hold_e136");
    check_at(137, 5'b10000, "t4_periph_e137");

    // rst during GAP after a timeout clears the sticky error
    init_done = 1'b0;
    do_reset();
    check_at(116, 5'b00010, "t5_fault_e116");
    check_at(132, 5'b10010, "t5_retry_e132");
    init_done = 1'b1;
    check_at(133, 5'b10010, "t5_gap_e133");
    rst = 1'b1;
    expect_next(5'b00000, "t5_rst_in_gap");
    tick();
    rst = 1'b0;
    cur_edge = 0;
    check_at(15, 5'b00000, "t5_hold_e15");
    check_at(16, 5'b10000, "t5_periph_e16");
    check_at(21, 5'b11100, "t5_run_e21");

`ifdef SOFT_RST_EN
    // Soft request leaves lockout, keeps timeout_err, and resets retry count
    init_done = 1'b0;
    do_reset();
    check_at(348, 5'b00011, "t6_lockout");
    soft_rst_req = 1'b1;
    expect_next(5'b00010, "t6_soft_hold");
    tick();
    soft_rst_req = 1'b0;
    cur_edge = 0;
    check_at(15, 5'b00010, "t6_hold_e15");
    check_at(16, 5'b10010, "t6_periph_e16");
    check_at(116, 5'b00010, "t6_fault_no_lock");
    check_at(132, 5'b10010, "t6_retry_after_soft");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
